// File: rtl/blink_sequencer.sv
// Table-driven sequencer: steps through (exponent, repeat) entries and drives the
// free-running count and one-hot mask consumed by the blinker stage.
module blink_sequencer #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic [15:0]   count,
    output logic [15:0]   mask,
    output logic [AW-1:0] entry_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [7:0]    tbl [DEPTH];
    logic [3:0]    rep_cnt;
    logic [3:0]    cur_e;
    logic [3:0]    cur_reps;
    logic [3:0]    next_reps;
    logic [3:0]    start_reps;
    logic [15:0]   period_mask;
    logic          period_end;
    logic          entry_last;
    logic          wr_fire;
    logic [AW-1:0] next_idx;

    always_comb begin
        cur_e       = tbl[entry_idx][7:4];
        cur_reps    = tbl[entry_idx][3:0];
        next_idx    = entry_idx + AW'(1);
        next_reps   = tbl[next_idx][3:0];
        // e = 15 shifts by 16, giving an all-ones mask that matches the 16-bit wrap
        period_mask = ~(16'hFFFF << ({1'b0, cur_e} + 5'd1));
        period_end  = (count & period_mask) == period_mask;
        entry_last  = (entry_idx == AW'(DEPTH - 1)) || (next_reps == 4'd0);
        wr_fire     = wr_valid && (state == IDLE);
        start_reps  = (wr_fire && wr_addr == '0) ? wr_data[3:0] : tbl[0][3:0];
        mask        = (state == RUN) ? (16'd1 << cur_e) : 16'h8000;
    end

    assign wr_ready = (state == IDLE);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rep_cnt   <= '0;
            entry_idx <= '0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_fire) tbl[wr_addr] <= wr_data;
                    if (start && start_reps != 4'd0) begin
                        state     <= RUN;
                        entry_idx <= '0;
                        count     <= '0;
                        rep_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        entry_idx <= '0;
                        count     <= '0;
                        rep_cnt   <= '0;
                    end else if (period_end) begin
                        if ({1'b0, rep_cnt} + 5'd1 < {1'b0, cur_reps}) begin
                            rep_cnt <= rep_cnt + 4'd1;
                            count   <= count + 16'd1;
                        end else begin
                            rep_cnt <= '0;
                            count   <= '0;
                            if (entry_last) begin
                                done      <= 1'b1;
                                entry_idx <= '0;
                                if (!loop) state <= IDLE;
                            end else begin
                                entry_idx <= next_idx;
                            end
                        end
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Program sequencer that owns the 16-bit free-running count and the one-hot mask consumed by the `blinker` stage, stepping through a small table of (rate, repeat) entries. Software or a host shim loads the table over a valid/ready write port while idle, then pulses `start`. The sequencer runs each entry for a programmed number of blink periods, then advances, wraps or stops. Its `count` and `mask` outputs connect directly to `blinker`'s `currentCount` and `mask` inputs.

## Interface
- DEPTH, 4: number of table entries; power of two, 2..16.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  table write request.
- wr_ready  out  1  write accepted when `wr_valid && wr_ready`.
- wr_addr  in  clog2(DEPTH)  entry index.
- wr_data  in  8  entry: [7:4] exponent `e` (mask bit), [3:0] repeat count `reps`.
- start  in  1  begin program at entry 0; sampled only in IDLE.
- stop  in  1  abort to IDLE; sampled only in RUN.
- loop  in  1  1 = wrap to entry 0 after the last entry; 0 = return to IDLE.
- count  out  16  to `blinker.currentCount`.
- mask  out  16  to `blinker.mask`, always one-hot.
- entry_idx  out  clog2(DEPTH)  entry currently running.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at program end (wrap or finish).

## Operation
- Table: DEPTH x 8-bit registers, all cleared to 0 by reset.
- FSM states: IDLE and RUN.
- IDLE:
  - `wr_ready` = 1; writes commit at the handshake edge.
  - `count` = 0, `mask` = 16'h8000, so the blink output is 0. `mask` is never driven to 0, because a 0 mask makes the blink output stick at 1.
- IDLE -> RUN on `start`, only if table[0].reps != 0; otherwise `start` is ignored.
  - A write and `start` in the same cycle are both accepted. Entry 0 is evaluated with the new data if `wr_addr` = 0.
  - `entry_idx` <= 0, `count` <= 0, `rep_cnt` <= 0.
- RUN:
  - `wr_ready` = 0 and writes stall.
  - `mask` = 1 << table[entry_idx].e (combinational from the table).
  - `count` increments every cycle, wrapping modulo 2^16.
- Period end: the cycle in which `count[e:0]` is all ones, i.e. every 2^(e+1) cycles.
  - If `rep_cnt + 1 < reps`: `rep_cnt` increments and `count` keeps incrementing.
  - Otherwise the entry ends: `rep_cnt` <= 0, `count` <= 0.
- Next entry: `entry_idx + 1`. The program ends instead if `entry_idx` = DEPTH-1 or the next entry's `reps` = 0 (end marker).
- Program end:
  - `done` pulses (registered, the cycle after the edge).
  - `loop` = 1: `entry_idx` <= 0 and RUN continues.
  - `loop` = 0: FSM -> IDLE.
  - `loop` is sampled at the end edge only.
- `stop` in RUN: -> IDLE at the next edge. `count`, `rep_cnt` and `entry_idx` are cleared, and `done` does not pulse. `stop` has priority over a simultaneous entry end or program end.
- `start` in RUN and `stop` in IDLE are ignored.
- `e` = 15 is legal: the period is 65536 cycles and the period end coincides with the 16-bit wrap.
- `reps` counts periods 1..15; 0 is only meaningful as the end marker.

## Timing
- Reset values: FSM IDLE, `count` 0, `mask` 16'h8000, `entry_idx` 0, `busy` 0, `done` 0, `wr_ready` 1, table 0.
- Reset asserted mid-RUN forces all of the above immediately, asynchronously.
- `start` -> `busy` = 1 and `count` = 0 in the first cycle after the edge. `count` = 1 in the following cycle.
- Entry run length: exactly `reps` x 2^(e+1) cycles, from `count` = 0 through the period-end cycle inclusive.
- Entry switch: zero dead cycles. The new `mask` and `count` = 0 appear in the cycle after the period-end edge.
- `done` is high in the same cycle as the first cycle of the wrapped entry 0, or the first IDLE cycle.
- Write latency: data readable by the FSM one cycle after the handshake.

## Test plan
- Reset mid-RUN with `count` = 37 -> all outputs take reset values at once. After release, `wr_ready` = 1 and `mask` = 16'h8000.
- Table {0: e=1,reps=2; 1: e=0,reps=3; 2: reps=0}, `loop` = 0, `start`:
  - `count` runs 0..7 with `mask` 16'h0002, then 0..5 with `mask` 16'h0001.
  - `done` pulses, then IDLE.
  - Blink output (`count & mask` == `mask`) is high on counts 2,3,6,7 of entry 0.
- Same table with `loop` = 1 -> entry 0 restarts right after entry 1 with no gap. `done` pulses every 14 cycles; the second wrap is checked.
- `stop` asserted on the period-end cycle of entry 0 -> IDLE next cycle, `entry_idx` 0, no `done`.
- Write attempt during RUN -> `wr_ready` = 0 and the table is unchanged.
- Write to addr 0 together with `start` in IDLE -> the new entry 0 runs.
- table[0].reps = 0 with `start` -> stays IDLE, `busy` stays 0.
- All DEPTH entries e=0, reps=1 -> each entry lasts 2 cycles, `done` fires after 2·DEPTH cycles via the DEPTH-1 wrap.
